snoopy_bus_controller: RTL and testbench

//  Arbitrates the shared snoopy bus among NUM_CACHES cache controllers and sequences each bus transaction:

---
 rtl/snoopy_bus_controller_pkg.sv | 33 +++
 rtl/snoopy_bus_controller_arbiter.sv | 33 +++
 rtl/snoopy_bus_controller.sv | 187 ++++++++++++++++++
 tb/tb_snoopy_bus_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/snoopy_bus_controller_pkg.sv
// Shared bus command encodings and helpers used by the snoopy bus controller.
package snoopy_bus_controller_pkg;

    localparam int CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        BUS_READ           = 2'd0,
        BUS_READ_EXCLUSIVE = 2'd1,
        BUS_INVALIDATE     = 2'd2,
        BUS_WRITEBACK      = 2'd3
    } command_t;

    // Commands that require a main-memory access once snooping has finished.
    function automatic logic needsMemory(input command_t cmd);
        logic result;
        case (cmd)
            BUS_READ, BUS_READ_EXCLUSIVE, BUS_WRITEBACK: result = 1'b1;
            default:                                      result = 1'b0;
        endcase
        return result;
    endfunction

    // Only writebacks write memory; every other memory command is a read.
    function automatic logic isMemoryWrite(input command_t cmd);
        logic result;
        case (cmd)
            BUS_WRITEBACK: result = 1'b1;
            default:       result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/snoopy_bus_controller_arbiter.sv
// Combinational round-robin arbiter: first requester at or after pointer wins.
module round_robin_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     request,
    input  logic [PTR_W-1:0] pointer,
    output logic [N-1:0]     winner,
    output logic [PTR_W-1:0] winner_index
);

    int   idx_s;
    logic found_s;

    // Scan requesters starting at the pointer, wrapping around, keep the first hit.
    always_comb begin
        winner       = '0;
        winner_index = '0;
        found_s      = 1'b0;
        idx_s        = 0;
        for (int i = 0; i < N; i++) begin
            idx_s = (int'(pointer) + i) % N;
            if (!found_s && request[idx_s]) begin
                found_s        = 1'b1;
                winner[idx_s]  = 1'b1;
                winner_index   = PTR_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/snoopy_bus_controller.sv
// Snoopy bus controller: arbitrates the shared bus and sequences
// grant -> snoop broadcast -> ack collection -> optional memory -> done.
module snoopy_bus_controller
    import snoopy_bus_controller_pkg::*;
#(
    parameter int NUM_CACHES    = 4,
    parameter int ADDRESS_WIDTH = 16,
    parameter int COMMAND_WIDTH = CMD_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_CACHES-1:0]               request,
    input  logic [NUM_CACHES*COMMAND_WIDTH-1:0] commandIn,
    input  logic [NUM_CACHES*ADDRESS_WIDTH-1:0] addressIn,
    output logic [NUM_CACHES-1:0]               grant,
    output logic                                busValid,
    output logic [COMMAND_WIDTH-1:0]            busCommand,
    output logic [ADDRESS_WIDTH-1:0]            busAddress,
    input  logic [NUM_CACHES-1:0]               snoopAck,
    output logic                                memRequest,
    output logic                                memWrite,
    input  logic                                memAck,
    output logic [NUM_CACHES-1:0]               done
);

    localparam int PTR_W = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        MEMORY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                    state_r, state_nx_s;
    logic [NUM_CACHES-1:0]     grant_r, grant_nx_s;
    logic                      bus_valid_r, bus_valid_nx_s;
    logic [COMMAND_WIDTH-1:0]  cmd_r, cmd_nx_s;
    logic [ADDRESS_WIDTH-1:0]  addr_r, addr_nx_s;
    logic                      mem_req_r, mem_req_nx_s;
    logic                      mem_wr_r, mem_wr_nx_s;
    logic [NUM_CACHES-1:0]     done_r, done_nx_s;
    logic [NUM_CACHES-1:0]     ack_seen_r, ack_seen_nx_s;
    logic [PTR_W-1:0]          ptr_r, ptr_nx_s;
    logic [PTR_W-1:0]          owner_r, owner_nx_s;
    logic [NUM_CACHES-1:0]     winner_s;
    logic [PTR_W-1:0]          winner_idx_s;
    logic                      all_acked_s;
    logic                      cmd_needs_mem_s;
    logic                      cmd_is_write_s;

    round_robin_arbiter #(.N(NUM_CACHES), .PTR_W(PTR_W)) u_arbiter (
        .request      (request),
        .pointer      (ptr_r),
        .winner       (winner_s),
        .winner_index (winner_idx_s)
    );

    // The owner never has to snoop its own request, so its bit counts as acked.
    assign all_acked_s     = &(ack_seen_r | snoopAck | grant_r);
    assign cmd_needs_mem_s = needsMemory(command_t'(cmd_r));
    assign cmd_is_write_s  = isMemoryWrite(command_t'(cmd_r));

    // State and all registered outputs; async clear on reset assertion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            bus_valid_r <= 1'b0;
            cmd_r       <= '0;
            addr_r      <= '0;
            mem_req_r   <= 1'b0;
            mem_wr_r    <= 1'b0;
            done_r      <= '0;
            ack_seen_r  <= '0;
            ptr_r       <= '0;
            owner_r     <= '0;
        end else begin
            state_r     <= state_nx_s;
            grant_r     <= grant_nx_s;
            bus_valid_r <= bus_valid_nx_s;
            cmd_r       <= cmd_nx_s;
            addr_r      <= addr_nx_s;
            mem_req_r   <= mem_req_nx_s;
            mem_wr_r    <= mem_wr_nx_s;
            done_r      <= done_nx_s;
            ack_seen_r  <= ack_seen_nx_s;
            ptr_r       <= ptr_nx_s;
            owner_r     <= owner_nx_s;
        end
    end

    // Next-state selection for the transaction sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (|request) state_nx_s = SNOOP;
                else          state_nx_s = IDLE;
            end
            SNOOP: begin
                if (all_acked_s) begin
                    if (cmd_needs_mem_s) state_nx_s = MEMORY;
                    else                 state_nx_s = DONE;
                end else begin
                    state_nx_s = SNOOP;
                end
            end
            MEMORY: begin
                if (memAck) state_nx_s = DONE;
                else        state_nx_s = MEMORY;
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping for each state.
    always_comb begin
        grant_nx_s     = grant_r;
        bus_valid_nx_s = bus_valid_r;
        cmd_nx_s       = cmd_r;
        addr_nx_s      = addr_r;
        mem_req_nx_s   = mem_req_r;
        mem_wr_nx_s    = mem_wr_r;
        done_nx_s      = '0;
        ack_seen_nx_s  = ack_seen_r;
        ptr_nx_s       = ptr_r;
        owner_nx_s     = owner_r;
        case (state_r)
            IDLE: begin
                if (|request) begin
                    grant_nx_s     = winner_s;
                    bus_valid_nx_s = 1'b1;
                    cmd_nx_s       = commandIn[int'(winner_idx_s)*COMMAND_WIDTH +: COMMAND_WIDTH];
                    addr_nx_s      = addressIn[int'(winner_idx_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    owner_nx_s     = winner_idx_s;
                    ack_seen_nx_s  = '0;
                end else begin
                    grant_nx_s = '0;
                end
            end
            SNOOP: begin
                ack_seen_nx_s = ack_seen_r | snoopAck | grant_r;
                if (all_acked_s) begin
                    bus_valid_nx_s = 1'b0;
                    if (cmd_needs_mem_s) begin
                        mem_req_nx_s = 1'b1;
                        mem_wr_nx_s  = cmd_is_write_s;
                    end else begin
                        done_nx_s  = grant_r;
                        grant_nx_s = '0;
                    end
                end else begin
                    bus_valid_nx_s = 1'b1;
                end
            end
            MEMORY: begin
                if (memAck) begin
                    mem_req_nx_s = 1'b0;
                    mem_wr_nx_s  = 1'b0;
                    done_nx_s    = grant_r;
                    grant_nx_s   = '0;
                end else begin
                    mem_req_nx_s = 1'b1;
                end
            end
            DONE: begin
                ack_seen_nx_s = '0;
                if (owner_r == PTR_W'(NUM_CACHES - 1)) ptr_nx_s = '0;
                else                                   ptr_nx_s = owner_r + PTR_W'(1);
            end
            default: begin
                grant_nx_s = '0;
            end
        endcase
    end

    assign grant      = grant_r;
    assign busValid   = bus_valid_r;
    assign busCommand = cmd_r;
    assign busAddress = addr_r;
    assign memRequest = mem_req_r;
    assign memWrite   = mem_wr_r;
    assign done       = done_r;

endmodule

// File: tb/tb_snoopy_bus_controller.sv
// Directed self-checking bench for snoopy_bus_controller.
module tb_snoopy_bus_controller;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int CW = 2;

    logic              clock;
    logic              reset;
    logic [NC-1:0]     request;
    logic [NC*CW-1:0]  commandIn;
    logic [NC*AW-1:0]  addressIn;
    logic [NC-1:0]     grant;
    logic              busValid;
    logic [CW-1:0]     busCommand;
    logic [AW-1:0]     busAddress;
    logic [NC-1:0]     snoopAck;
    logic              memRequest;
    logic              memWrite;
    logic              memAck;
    logic [NC-1:0]     done;

    int checks_cnt = 0;
    int errors_cnt = 0;

    snoopy_bus_controller #(.NUM_CACHES(NC), .ADDRESS_WIDTH(AW), .COMMAND_WIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .commandIn  (commandIn),
        .addressIn  (addressIn),
        .grant      (grant),
        .busValid   (busValid),
        .busCommand (busCommand),
        .busAddress (busAddress),
        .snoopAck   (snoopAck),
        .memRequest (memRequest),
        .memWrite   (memWrite),
        .memAck     (memAck),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_cache(input int i, input logic [CW-1:0] cmd, input logic [AW-1:0] addr);
        commandIn[i*CW +: CW] = cmd;
        addressIn[i*AW +: AW] = addr;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_grant"},   32'(grant),      32'd0);
        check_value({tag, "_valid"},   32'(busValid),   32'd0);
        check_value({tag, "_cmd"},     32'(busCommand), 32'd0);
        check_value({tag, "_addr"},    32'(busAddress), 32'd0);
        check_value({tag, "_memreq"},  32'(memRequest), 32'd0);
        check_value({tag, "_memwr"},   32'(memWrite),   32'd0);
        check_value({tag, "_done"},    32'(done),       32'd0);
    endtask

    initial begin
        logic [AW-1:0] wb_addr [NC];
        int            exp_owner;

        reset     = 1'b0;
        request   = '0;
        commandIn = '0;
        addressIn = '0;
        snoopAck  = '0;
        memAck    = 1'b0;
        wb_addr[0] = 16'hA000;
        wb_addr[1] = 16'hA111;
        wb_addr[2] = 16'hA222;
        wb_addr[3] = 16'hA333;

        // Reset state
        tick();
        check_all_zero("reset");
        reset = 1'b1;

        // Cache1 BUS_INVALIDATE 0x0040, all acks together
        set_cache(1, 2'd2, 16'h0040);
        request = 4'b0010;
        tick();
        check_value("inv_grant", 32'(grant),      32'h2);
        check_value("inv_valid", 32'(busValid),   32'h1);
        check_value("inv_cmd",   32'(busCommand), 32'h2);
        check_value("inv_addr",  32'(busAddress), 32'h0040);
        snoopAck = 4'b1111;
        tick();
        check_value("inv_done",   32'(done),       32'h2);
        check_value("inv_grant0", 32'(grant),      32'h0);
        check_value("inv_valid0", 32'(busValid),   32'h0);
        check_value("inv_nomem",  32'(memRequest), 32'h0);
        snoopAck = '0;
        request  = '0;
        tick();
        check_value("inv_done_1cyc", 32'(done), 32'h0);

        // Cache2 BUS_READ 0x1234, staggered acks, memAck two cycles later
        set_cache(2, 2'd0, 16'h1234);
        request = 4'b0100;
        tick();
        check_value("rd_grant", 32'(grant),      32'h4);
        check_value("rd_addr",  32'(busAddress), 32'h1234);
        check_value("rd_cmd",   32'(busCommand), 32'h0);
        snoopAck = 4'b0001;
        tick();
        check_value("rd_wait1", 32'(busValid), 32'h1);
        snoopAck = 4'b0010;
        tick();
        check_value("rd_wait2",   32'(busValid),   32'h1);
        check_value("rd_nomem_y", 32'(memRequest), 32'h0);
        snoopAck = 4'b1000;
        tick();
        check_value("rd_memreq", 32'(memRequest), 32'h1);
        check_value("rd_memwr",  32'(memWrite),   32'h0);
        check_value("rd_valid0", 32'(busValid),   32'h0);
        snoopAck = '0;
        tick();
        check_value("rd_hold1", 32'(memRequest), 32'h1);
        tick();
        check_value("rd_hold2", 32'(memRequest), 32'h1);
        check_value("rd_nodone", 32'(done),      32'h0);
        memAck = 1'b1;
        tick();
        check_value("rd_done",    32'(done),       32'h4);
        check_value("rd_memreq0", 32'(memRequest), 32'h0);
        memAck  = 1'b0;
        request = '0;
        tick();

        // Reset so rotation starts at cache0, then all four write back continuously
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NC; i++) set_cache(i, 2'd3, wb_addr[i]);
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_owner = k % NC;
            tick();
            check_value($sformatf("wb%0d_grant", k), 32'(grant),      32'(1) << exp_owner);
            check_value($sformatf("wb%0d_addr", k),  32'(busAddress), 32'(wb_addr[exp_owner]));
            snoopAck = 4'b1111;
            tick();
            check_value($sformatf("wb%0d_memreq", k), 32'(memRequest), 32'h1);
            check_value($sformatf("wb%0d_memwr", k),  32'(memWrite),   32'h1);
            snoopAck = '0;
            memAck   = 1'b1;
            tick();
            check_value($sformatf("wb%0d_done", k), 32'(done), 32'(1) << exp_owner);
            memAck = 1'b0;
            tick();
        end
        request = '0;
        tick();

        // Owner (cache3, pointer at 1) keeps its own ack low
        set_cache(3, 2'd2, 16'h0300);
        request = 4'b1000;
        tick();
        check_value("own_grant", 32'(grant), 32'h8);
        snoopAck = 4'b0111;
        tick();
        check_value("own_done", 32'(done), 32'h8);
        snoopAck = '0;
        request  = '0;
        tick();

        // Pointer wrapped to 0: cache1 read goes to MEMORY, then reset hits mid-cycle
        set_cache(1, 2'd0, 16'h0111);
        set_cache(0, 2'd2, 16'h0000);
        request = 4'b0010;
        tick();
        check_value("rst_grant", 32'(grant), 32'h2);
        snoopAck = 4'b1111;
        tick();
        check_value("rst_inmem", 32'(memRequest), 32'h1);
        snoopAck = '0;
        request  = 4'b0011;
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clock);
        reset = 1'b1;
        tick();
        check_value("rst_regrant", 32'(grant), 32'h1);
        snoopAck = 4'b1111;
        tick();
        check_value("rst_done0", 32'(done), 32'h1);
        snoopAck = '0;
        request  = '0;
        tick();

        // Owner drops request and changes its inputs during SNOOP; a new request waits
        set_cache(1, 2'd2, 16'h0040);
        request = 4'b0010;
        tick();
        check_value("drop_grant", 32'(grant), 32'h2);
        request = 4'b0100;
        set_cache(1, 2'd0, 16'hBEEF);
        tick();
        check_value("drop_addr",  32'(busAddress), 32'h0040);
        check_value("drop_cmd",   32'(busCommand), 32'h2);
        check_value("drop_owner", 32'(grant),      32'h2);
        snoopAck = 4'b1111;
        tick();
        check_value("drop_done",  32'(done),       32'h2);
        check_value("drop_nomem", 32'(memRequest), 32'h0);
        snoopAck = '0;
        request  = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
